c66x_power_supervisor: RTL

Board-level supervisor that owns the `enable` input of the C66x power sequencer. It generates the 100 µs timebase, holds the DSP off for 10 ms after CPLD power-on, and turns the host power request into sequencer enable. It detects failed or aborted power-ups and in-service drops, retries with exponential backoff, and latches a lockout fault after repeated failures. It sits between the host/GPIO logic and the sequencer, and observes only the sequencer's `off` and `on` state decodes.

---
 rtl/c66x_power_supervisor.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/c66x_power_supervisor.sv
// rtl/c66x_power_supervisor.sv - C66x sequencer enable supervisor: boot hold-off, retry backoff, lockout
// Optional feature macro: C66X_SUPERVISOR_AUTORETRY_EN (undefined: first failure locks out directly)
module c66x_power_supervisor #(
  parameter int TICK_DIV            = 500,
  parameter int STARTUP_TICKS       = 100,
  parameter int START_TIMEOUT_TICKS = 1000,
  parameter int RETRY_TICKS         = 250,
  parameter int STABLE_TICKS        = 1000,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       power_req,
  input  logic       clear_fault,
  input  logic       seq_off,
  input  logic       seq_on,
  output logic       seq_enable,
  output logic       tick,
  output logic       fault,
  output logic [1:0] retry_count,
  output logic [2:0] sup_state
);

  localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [15:0]     STARTUP_T  = 16'(STARTUP_TICKS);
  localparam logic [15:0]     START_TO_T = 16'(START_TIMEOUT_TICKS);
  localparam logic [15:0]     STABLE_T   = 16'(STABLE_TICKS);

  typedef enum logic [2:0] {
    BOOT_WAIT = 3'd0,
    IDLE      = 3'd1,
    STARTING  = 3'd2,
    RUNNING   = 3'd3,
    BACKOFF   = 3'd4,
    STOPPING  = 3'd5,
    LOCKOUT   = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   timer_q, timer_d;
  logic          left_off_q, left_off_d;
  logic [1:0]    retry_q, retry_d;
  logic          fail;

`ifdef C66X_SUPERVISOR_AUTORETRY_EN
  localparam logic [15:0] RETRY_T = 16'(RETRY_TICKS);
  localparam logic [1:0]  MAX_R   = 2'(MAX_RETRIES);
  logic [1:0]  retry_inc;
  logic [18:0] backoff_lim;
  assign retry_inc   = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
  assign backoff_lim = {3'b000, RETRY_T} << (retry_q - 2'd1);
`endif

  assign tick = (presc_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    fail    = 1'b0;
    case (state_q)
      BOOT_WAIT: if (timer_q == STARTUP_T) state_d = IDLE;
      IDLE:      if (power_req && seq_off) state_d = STARTING;
      STARTING: begin
        if (seq_on)                                              state_d = RUNNING;
        else if (!power_req)                                     state_d = STOPPING;
        else if ((timer_q == START_TO_T) || (seq_off && left_off_q)) fail = 1'b1;
      end
      RUNNING: begin
        if (!seq_on)                   fail    = 1'b1;
        else if (!power_req)           state_d = STOPPING;
        else if (timer_q == STABLE_T)  retry_d = 2'd0;
      end
`ifdef C66X_SUPERVISOR_AUTORETRY_EN
      BACKOFF: begin
        if (({3'b000, timer_q} >= backoff_lim) && seq_off)
          state_d = power_req ? STARTING : IDLE;
      end
`endif
      STOPPING:  if (seq_off) state_d = IDLE;
      LOCKOUT: begin
        if (clear_fault && seq_off) begin
          state_d = IDLE;
          retry_d = 2'd0;
        end
      end
      default:   state_d = IDLE;
    endcase

    if (fail) begin
`ifdef C66X_SUPERVISOR_AUTORETRY_EN
      retry_d = retry_inc;
      state_d = (retry_inc >= MAX_R) ? LOCKOUT : BACKOFF;
`else
      retry_d = 2'd1;
      state_d = LOCKOUT;
`endif
    end
  end

  // Prescaler free-runs; the timer restarts on every state change and saturates.
  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    if (state_d != state_q)
      timer_d = 16'd0;
    else if (tick && (timer_q != 16'hFFFF))
      timer_d = timer_q + 16'd1;
    else
      timer_d = timer_q;
    if (state_d != state_q)
      left_off_d = 1'b0;
    else if ((state_q == STARTING) && !seq_off)
      left_off_d = 1'b1;
    else
      left_off_d = left_off_q;
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q    <= BOOT_WAIT;
      presc_q    <= '0;
      timer_q    <= 16'd0;
      left_off_q <= 1'b0;
      retry_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      timer_q    <= timer_d;
      left_off_q <= left_off_d;
      retry_q    <= retry_d;
    end
  end

  assign seq_enable  = (state_q == STARTING) || (state_q == RUNNING);
  assign fault       = (state_q == LOCKOUT);
  assign retry_count = retry_q;
  assign sup_state   = state_q;

endmodule
